// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing definitions.
// Holds the 1024x768@60 (VESA XGA) timing constants, the 11-bit count width and a
// helper that sums the four segments of one axis. Imported by the timing generator
// and by any controller (menu, game, top) that needs to reason about screen geometry.
package vga_timing_gen_pkg;

   localparam int unsigned CNT_W   = 11;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   typedef logic [CNT_W-1:0] cnt_t;

   // 1024x768@60, 65 MHz pixel clock
   localparam int unsigned XGA_H_ACTIVE = 1024;
   localparam int unsigned XGA_H_FP     = 24;
   localparam int unsigned XGA_H_SYNC   = 136;
   localparam int unsigned XGA_H_BP     = 160;
   localparam int unsigned XGA_V_ACTIVE = 768;
   localparam int unsigned XGA_V_FP     = 3;
   localparam int unsigned XGA_V_SYNC   = 6;
   localparam int unsigned XGA_V_BP     = 29;
   localparam logic        XGA_SYNC_POL = 1'b0;

   function automatic int unsigned axis_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One display axis: wrapping position counter plus registered blank/sync decode.
// Flags are decoded from the next-state count so the registered flags line up with
// the registered count they describe.
//   pclk    : clock
//   rst     : synchronous, active-high reset (count 0, blank 0, sync inactive)
//   step_i  : advance the counter this cycle
//   count_o : current position, 0..TOTAL-1
//   wrap_o  : combinational, high when this cycle's step takes the count back to 0
//   blank_o : high when count is outside the active region
//   sync_o  : SYNC_POL while count is inside the sync pulse, else ~SYNC_POL
module vga_axis_counter
   import vga_timing_gen_pkg::*;
#(
   parameter int unsigned ACTIVE   = XGA_H_ACTIVE,
   parameter int unsigned FP       = XGA_H_FP,
   parameter int unsigned SYNC     = XGA_H_SYNC,
   parameter int unsigned BP       = XGA_H_BP,
   parameter logic        SYNC_POL = XGA_SYNC_POL
) (
   input  logic pclk,
   input  logic rst,
   input  logic step_i,
   output cnt_t count_o,
   output logic wrap_o,
   output logic blank_o,
   output logic sync_o
);

   localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

   if (TOTAL > CNT_MAX || TOTAL < 2) begin : g_bad_total
      $error("vga_axis_counter: axis total %0d does not fit the count range", TOTAL);
   end

   localparam cnt_t LAST       = cnt_t'(TOTAL - 1);
   localparam cnt_t ACT_END    = cnt_t'(ACTIVE);
   localparam cnt_t SYNC_START = cnt_t'(ACTIVE + FP);
   localparam cnt_t SYNC_END   = cnt_t'(ACTIVE + FP + SYNC);

   cnt_t count_q, count_d;
   logic blank_q, blank_d;
   logic sync_q, sync_d;

   assign wrap_o = step_i && (count_q == LAST);

   always_comb begin
      count_d = count_q;
      if (step_i) begin
         count_d = (count_q == LAST) ? '0 : count_q + cnt_t'(1);
      end
      blank_d = (count_d >= ACT_END);
      sync_d  = ((count_d >= SYNC_START) && (count_d < SYNC_END)) ? SYNC_POL : ~SYNC_POL;
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         count_q <= '0;
         blank_q <= 1'b0;
         sync_q  <= ~SYNC_POL;
      end else begin
         count_q <= count_d;
         blank_q <= blank_d;
         sync_q  <= sync_d;
      end
   end

   assign count_o = count_q;
   assign blank_o = blank_q;
   assign sync_o  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator (default 1024x768@60).
// Horizontal and vertical axes are two instances of vga_axis_counter; the vertical
// axis steps only on the horizontal wrap. All outputs are registered and describe the
// same (hcount, vcount) pair. en=0 freezes everything and forces sof/eol low.
//   pclk, rst     : pixel clock, synchronous active-high reset (overrides en)
//   en            : count enable
//   hcount_out    : pixel index in line       vcount_out : line index in frame
//   hsync_out     : horizontal sync           vsync_out  : vertical sync
//   hblnk_out     : outside horizontal active vblnk_out  : outside vertical active
//   sof_out       : pulse when (0,0) is entered by counting
//   eol_out       : pulse when hcount shows H_TOTAL-1
//   frame_cnt_out : completed frames, wraps at 16 bits
module vga_timing_gen
   import vga_timing_gen_pkg::*;
#(
   parameter int unsigned H_ACTIVE = XGA_H_ACTIVE,
   parameter int unsigned H_FP     = XGA_H_FP,
   parameter int unsigned H_SYNC   = XGA_H_SYNC,
   parameter int unsigned H_BP     = XGA_H_BP,
   parameter int unsigned V_ACTIVE = XGA_V_ACTIVE,
   parameter int unsigned V_FP     = XGA_V_FP,
   parameter int unsigned V_SYNC   = XGA_V_SYNC,
   parameter int unsigned V_BP     = XGA_V_BP,
   parameter logic        SYNC_POL = XGA_SYNC_POL
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        en,
   output cnt_t        hcount_out,
   output cnt_t        vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic        sof_out,
   output logic        eol_out,
   output logic [15:0] frame_cnt_out
);

   localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   // eol is registered, so it is raised on the step that lands on H_TOTAL-1
   localparam cnt_t H_PRE_LAST = cnt_t'(H_TOTAL - 2);

   cnt_t        hcount, vcount;
   logic        h_wrap, v_wrap, v_step;
   logic        sof_q, sof_d;
   logic        eol_q, eol_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;

   assign v_step = en && h_wrap;

   vga_axis_counter #(
      .ACTIVE   (H_ACTIVE),
      .FP       (H_FP),
      .SYNC     (H_SYNC),
      .BP       (H_BP),
      .SYNC_POL (SYNC_POL)
   ) u_h_axis (
      .pclk    (pclk),
      .rst     (rst),
      .step_i  (en),
      .count_o (hcount),
      .wrap_o  (h_wrap),
      .blank_o (hblnk_out),
      .sync_o  (hsync_out)
   );

   vga_axis_counter #(
      .ACTIVE   (V_ACTIVE),
      .FP       (V_FP),
      .SYNC     (V_SYNC),
      .BP       (V_BP),
      .SYNC_POL (SYNC_POL)
   ) u_v_axis (
      .pclk    (pclk),
      .rst     (rst),
      .step_i  (v_step),
      .count_o (vcount),
      .wrap_o  (v_wrap),
      .blank_o (vblnk_out),
      .sync_o  (vsync_out)
   );

   always_comb begin
      // v_wrap already implies en and a horizontal wrap
      sof_d       = v_wrap;
      eol_d       = en && (hcount == H_PRE_LAST);
      frame_cnt_d = frame_cnt_q;
      if (v_wrap) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         sof_q       <= 1'b0;
         eol_q       <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         sof_q       <= sof_d;
         eol_q       <= eol_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign hcount_out    = hcount;
   assign vcount_out    = vcount;
   assign sof_out       = sof_q;
   assign eol_out       = eol_q;
   assign frame_cnt_out = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Horizontal timing uses the XGA defaults; the
// vertical axis is shortened (8 active, 1 FP, 2 sync, 3 BP -> 14 lines, vsync on
// lines 9..10) so whole frames fit in a short run.
module tb_vga_timing_gen;

   localparam int HT = 1344;
   localparam int VT = 14;

   logic        pclk = 1'b0;
   logic        rst;
   logic        en;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out, vsync_out, hblnk_out, vblnk_out, sof_out, eol_out;
   logic [15:0] frame_cnt_out;

   int          errors = 0;
   int          checks = 0;

   int          exp_h, exp_v;
   logic [15:0] exp_fc;
   logic        exp_sof, exp_eol;

   always #5 pclk = ~pclk;

   vga_timing_gen #(
      .V_ACTIVE (8),
      .V_FP     (1),
      .V_SYNC   (2),
      .V_BP     (3)
   ) dut (
      .pclk          (pclk),
      .rst           (rst),
      .en            (en),
      .hcount_out    (hcount_out),
      .vcount_out    (vcount_out),
      .hsync_out     (hsync_out),
      .vsync_out     (vsync_out),
      .hblnk_out     (hblnk_out),
      .vblnk_out     (vblnk_out),
      .sof_out       (sof_out),
      .eol_out       (eol_out),
      .frame_cnt_out (frame_cnt_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      logic hs, vs;
      hs = (exp_h >= 1048 && exp_h < 1184) ? 1'b0 : 1'b1;
      vs = (exp_v >= 9 && exp_v < 11) ? 1'b0 : 1'b1;
      check("hcount", hcount_out, exp_h);
      check("vcount", vcount_out, exp_v);
      check("hsync", hsync_out, hs);
      check("vsync", vsync_out, vs);
      check("hblnk", hblnk_out, (exp_h >= 1024) ? 1'b1 : 1'b0);
      check("vblnk", vblnk_out, (exp_v >= 8) ? 1'b1 : 1'b0);
      check("sof", sof_out, exp_sof);
      check("eol", eol_out, exp_eol);
      check("frame_cnt", frame_cnt_out, exp_fc);
   endtask

   // Advance the reference by one pclk edge, then sample 1 time unit after the edge.
   task automatic tick();
      if (rst) begin
         exp_h = 0; exp_v = 0; exp_fc = '0; exp_sof = 1'b0; exp_eol = 1'b0;
      end else if (en) begin
         exp_sof = 1'b0;
         if (exp_h == HT - 1) begin
            exp_h = 0;
            if (exp_v == VT - 1) begin
               exp_v   = 0;
               exp_sof = 1'b1;
               exp_fc  = exp_fc + 16'd1;
            end else begin
               exp_v++;
            end
         end else begin
            exp_h++;
         end
         exp_eol = (exp_h == HT - 1);
      end else begin
         exp_sof = 1'b0;
         exp_eol = 1'b0;
      end
      @(posedge pclk);
      #1;
      check_model();
   endtask

   initial begin
      int eol_seen, eol_at, sof_seen, vs_first, vs_last, vb_first, vb_last, cyc;
      logic got;

      // Reset, with en high to show rst wins
      rst = 1'b1;
      en  = 1'b1;
      tick();
      tick();
      check("rst_hcount", hcount_out, 0);
      check("rst_vcount", vcount_out, 0);
      check("rst_hsync", hsync_out, 1'b1);
      check("rst_vsync", vsync_out, 1'b1);
      check("rst_frame_cnt", frame_cnt_out, 16'h0000);

      // One full line
      rst = 1'b0;
      eol_seen = 0;
      eol_at   = -1;
      for (int i = 1; i <= HT; i++) begin
         tick();
         if (eol_out) begin
            eol_seen++;
            eol_at = hcount_out;
         end
         if (i == 1023) check("hblnk@1023", hblnk_out, 1'b0);
         if (i == 1024) check("hblnk@1024", hblnk_out, 1'b1);
         if (i == 1343) check("hblnk@1343", hblnk_out, 1'b1);
         if (i == 1047) check("hsync@1047", hsync_out, 1'b1);
         if (i == 1048) check("hsync@1048", hsync_out, 1'b0);
         if (i == 1183) check("hsync@1183", hsync_out, 1'b0);
         if (i == 1184) check("hsync@1184", hsync_out, 1'b1);
      end
      check("eol_pulses", eol_seen, 1);
      check("eol_at", eol_at, 1343);
      check("line_wrap_h", hcount_out, 0);
      check("line_wrap_v", vcount_out, 1);

      // Rest of the first frame
      sof_seen = 0;
      vs_first = -1; vs_last = -1; vb_first = -1; vb_last = -1;
      for (int i = 0; i < (VT - 1) * HT; i++) begin
         tick();
         if (sof_out) sof_seen++;
         if (!vsync_out) begin
            if (vs_first < 0) vs_first = vcount_out;
            vs_last = vcount_out;
         end
         if (vblnk_out) begin
            if (vb_first < 0) vb_first = vcount_out;
            vb_last = vcount_out;
         end
      end
      check("frame_sof_count", sof_seen, 1);
      check("frame_sof_now", sof_out, 1'b1);
      check("vsync_first", vs_first, 9);
      check("vsync_last", vs_last, 10);
      check("vblnk_first", vb_first, 8);
      check("vblnk_last", vb_last, 13);
      check("frame_cnt_1", frame_cnt_out, 16'h0001);

      // Freeze at (500,3)
      for (int i = 0; i < 3 * HT + 500; i++) tick();
      check("pre_hold_h", hcount_out, 500);
      check("pre_hold_v", vcount_out, 3);
      en = 1'b0;
      for (int i = 0; i < 100; i++) tick();
      check("hold_h", hcount_out, 500);
      check("hold_v", vcount_out, 3);
      check("hold_sof", sof_out, 1'b0);
      check("hold_eol", eol_out, 1'b0);
      check("hold_frame_cnt", frame_cnt_out, 16'h0001);
      en = 1'b1;
      tick();
      check("resume_h", hcount_out, 501);

      // Mid-frame reset at (700,6)
      for (int i = 0; i < 3 * HT + 199; i++) tick();
      check("pre_rst_h", hcount_out, 700);
      check("pre_rst_v", vcount_out, 6);
      rst = 1'b1;
      tick();
      check("mid_rst_h", hcount_out, 0);
      check("mid_rst_v", vcount_out, 0);
      check("mid_rst_frame_cnt", frame_cnt_out, 16'h0000);
      check("mid_rst_hsync", hsync_out, 1'b1);
      check("mid_rst_vsync", vsync_out, 1'b1);
      check("mid_rst_sof", sof_out, 1'b0);
      rst = 1'b0;

      // First sof after release, with frame_cnt preloaded to 0xFFFF
      got = 1'b0;
      cyc = 0;
      for (int n = 0; n < 20000 && !got; n++) begin
         tick();
         cyc++;
         if (cyc == 100) begin
            force dut.frame_cnt_q = 16'hFFFF;
            exp_fc = 16'hFFFF;
         end
         if (cyc == 101) begin
            release dut.frame_cnt_q;
         end
         if (cyc == 102) check("fc_preload", frame_cnt_out, 16'hFFFF);
         if (sof_out) got = 1'b1;
      end
      check("sof_seen", got, 1'b1);
      check("sof_latency", cyc, HT * VT);
      check("fc_wrap", frame_cnt_out, 16'h0000);
      check("fc_wrap_h", hcount_out, 0);
      check("fc_wrap_v", vcount_out, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch, pixels
- H_SYNC, 136, horizontal sync width, pixels
- H_BP, 160, horizontal back porch, pixels
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch, lines
- V_SYNC, 6, vertical sync width, lines
- V_BP, 29, vertical back porch, lines
- SYNC_POL, 1'b0, asserted sync level (0 = active-low, VESA 1024x768@60)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning:
- pclk  in  1  pixel clock, 65 MHz
- rst  in  1  synchronous, active-high reset
- en  in  1  count enable; when low, all outputs hold
- hcount_out  out  11  pixel index in line, 0..H_TOTAL-1
- vcount_out  out  11  line index in frame, 0..V_TOTAL-1
- hsync_out  out  1  horizontal sync, level per SYNC_POL
- vsync_out  out  1  vertical sync, level per SYNC_POL
- hblnk_out  out  1  high when outside horizontal active region
- vblnk_out  out  1  high when outside vertical active region
- sof_out  out  1  one-cycle pulse at hcount=0, vcount=0
- eol_out  out  1  one-cycle pulse at hcount=H_TOTAL-1
- frame_cnt_out  out  16  completed-frame counter

Function
REQ-003 H_TOTAL SHALL be H_ACTIVE+H_FP+H_SYNC+H_BP (1344); V_TOTAL SHALL be V_ACTIVE+V_FP+V_SYNC+V_BP (806).
REQ-004 On each pclk edge with en=1, hcount SHALL increment by 1; at H_TOTAL-1 it SHALL wrap to 0.
REQ-005 vcount SHALL increment only on the cycle hcount wraps; at V_TOTAL-1 with hcount wrapping it SHALL wrap to 0.
REQ-006 With en=0, hcount, vcount, and all derived outputs SHALL hold; sof_out and eol_out SHALL be 0.
REQ-007 All outputs SHALL be registered and mutually aligned: every flag SHALL be decoded from the same cycle's hcount/vcount values as presented.
REQ-008 hblnk_out SHALL be 1 iff hcount >= H_ACTIVE; vblnk_out SHALL be 1 iff vcount >= V_ACTIVE.
REQ-009 hsync_out SHALL equal SYNC_POL iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (1048..1183), else ~SYNC_POL.
REQ-010 vsync_out SHALL equal SYNC_POL iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (771..776), else ~SYNC_POL.
REQ-011 frame_cnt_out SHALL increment on the cycle both counters wrap to 0, wrapping 0xFFFF->0x0000.
REQ-012 sof_out SHALL be 1 exactly one cycle per frame, on the cycle the outputs show hcount=0, vcount=0 and en=1.
REQ-013 Arithmetic SHALL be unsigned 11-bit; parameter totals exceeding 2047 SHALL be rejected at elaboration.

Reset
REQ-014 With rst=1 at a pclk edge: hcount=0, vcount=0, hblnk=0, vblnk=0, syncs=~SYNC_POL, sof=0, eol=0, frame_cnt=0; rst overrides en.
REQ-015 Reset mid-frame SHALL restart at (0,0) on the next cycle without a partial-frame frame_cnt increment; first sof_out SHALL occur H_TOTAL*V_TOTAL cycles after reset release.

Structure
REQ-016 Shared package SHALL hold the 1024x768@60 timing constants and the 11-bit count width, for use by menu, game, and top controllers.
REQ-017 One sub-module SHALL be used: vga_axis_counter (generic counter + blank/sync decode), instantiated once for horizontal and once for vertical axes.

Verification
REQ-018 Bench SHALL cover:
- reset release, en=1, 1344 cycles -> hcount 0..1343 then 0, vcount 0->1, eol_out pulsed once at hcount=1343
- hcount 1047->1048 -> hsync_out 1->0; 1183->1184 -> 0->1; hblnk_out 1 from hcount 1024 to 1343
- full frame (1,083,264 cycles) -> vsync_out low for vcount 771..776, vblnk_out high for 768..805, sof_out once, frame_cnt_out=1
- en low 100 cycles at hcount=500,vcount=300 -> all outputs frozen, sof/eol 0; resume at 501
- rst at hcount=700,vcount=400 -> next cycle (0,0), frame_cnt_out=0, syncs inactive
- frame_cnt_out preloaded via force to 0xFFFF, frame end -> 0x0000
